// File: rtl/down_count_pkg.sv
// down_count_pkg: shared state encoding and default width for the down_count slice.
package down_count_pkg;
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;
    localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/down_count_if.sv
// down_count_if: load/enable request and count/status response bundle for down_count.
interface down_count_if import down_count_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) ();
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             tc;
    logic             busy;
    modport master(output load, load_val, en, input out, zero, tc, busy);
    modport slave(input load, load_val, en, output out, zero, tc, busy);
endinterface

// File: rtl/down_count_ctrl.sv
// down_count_ctrl: IDLE/COUNT/DONE sequencing, terminal-count pulse and busy flag.
// DOWN_COUNT_AUTO_RELOAD_EN keeps the FSM in COUNT across the terminal step.
module down_count_ctrl import down_count_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic load_zero,
    input  logic en,
    input  logic one,
    output logic dec,
    output logic term,
    output logic tc,
    output logic busy
);
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
    localparam state_e TERM_STATE = COUNT;
`else
    localparam state_e TERM_STATE = DONE;
`endif
    state_e state_q, state_d;
    logic   tc_q, tc_d;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
        end
    end
    // load outranks the enable in every state, so it also suppresses a coincident terminal step
    always_comb begin
        dec     = !load && state_q == COUNT && en;
        term    = dec && one;
        tc_d    = term;
        state_d = load ? (load_zero ? DONE : COUNT) : term ? TERM_STATE : state_q;
    end
    assign tc   = tc_q;
    assign busy = state_q == COUNT;
endmodule

// File: rtl/down_count.sv
// down_count: loadable down-counter datapath (count, zero flag, optional reload register).
// DOWN_COUNT_AUTO_RELOAD_EN reloads the last loaded value on each terminal step.
module down_count import down_count_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
    input logic        clk,
    input logic        rst,
    down_count_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    logic [WIDTH-1:0] out_q, out_d, wrap;
    logic             zero_q, zero_d;
    logic             dec, term;
    down_count_ctrl u_ctrl (
        .clk(clk),
        .rst(rst),
        .load(bus.load),
        .load_zero(bus.load_val == '0),
        .en(bus.en),
        .one(out_q == ONE),
        .dec(dec),
        .term(term),
        .tc(bus.tc),
        .busy(bus.busy)
    );
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) reload_q <= '0;
        else      reload_q <= reload_d;
    end
    always_comb reload_d = bus.load ? bus.load_val : reload_q;
    assign wrap = reload_q;
`else
    assign wrap = '0;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            out_q  <= out_d;
            zero_q <= zero_d;
        end
    end
    // the terminal step replaces the decrement, so out never wraps below zero
    always_comb begin
        out_d  = bus.load ? bus.load_val : term ? wrap : dec ? out_q - ONE : out_q;
        zero_d = out_d == '0;
    end
    assign bus.out  = out_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_down_count.sv
// tb_down_count: vector table, corner-case sequences and randomized run against a behavioural model.
module tb_down_count;
    localparam int W = 4;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    down_count_if #(.WIDTH(W)) bus ();
    down_count #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic         l;
        logic [W-1:0] lv;
        logic         e;
        logic [W-1:0] o;
        logic         z, t, b;
    } vec_t;
    vec_t tbl[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] m_out, m_per;
    bit m_run, m_tc;
    task automatic model_reset();
        m_out = '0; m_per = '0; m_run = 1'b0; m_tc = 1'b0;
    endtask
    task automatic model_step(input logic l, input logic [W-1:0] lv, input logic e);
        m_tc = 1'b0;
        if (l) begin
            m_out = lv; m_per = lv; m_run = (lv != 0);
        end else if (m_run && e) begin
            if (m_out == 1) begin
                m_tc = 1'b1;
                if (AUTO) m_out = m_per;
                else begin m_out = '0; m_run = 1'b0; end
            end else m_out = m_out - 1;
        end
    endtask
    task automatic check(input string name, input logic [W-1:0] o, input logic z, t, b);
        n_cmp++;
        if ({bus.out, bus.zero, bus.tc, bus.busy} !== {o, z, t, b}) begin
            n_bad++;
            $display("FAIL %s: got out=%0d zero=%b tc=%b busy=%b, want out=%0d zero=%b tc=%b busy=%b",
                     name, bus.out, bus.zero, bus.tc, bus.busy, o, z, t, b);
        end
    endtask
    task automatic step(input logic l, input logic [W-1:0] lv, input logic e);
        bus.load = l; bus.load_val = lv; bus.en = e;
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else model_step(l, lv, e);
    endtask
    task automatic step_chk(input string name, input logic l, input logic [W-1:0] lv, input logic e);
        step(l, lv, e);
        check(name, m_out, m_out == 0, m_tc, m_run);
    endtask
    task automatic add(input logic l, input logic [W-1:0] lv, input logic e,
                       input logic [W-1:0] o, input logic z, t, b);
        vec_t v;
        v.l = l; v.lv = lv; v.e = e; v.o = o; v.z = z; v.t = t; v.b = b;
        tbl.push_back(v);
    endtask
    initial begin
        int tcs;
        bus.load = 1'b0; bus.load_val = '0; bus.en = 1'b1;
        model_reset();
        // reset held, then released with en high and no load
        for (int i = 0; i < 2; i++) step_chk("reset_hold", 1'b0, 4'd0, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step_chk("idle_en", 1'b0, 4'd0, 1'b1);
        add(1, 9, 0, 9, 0, 0, 1);
        add(0, 0, 1, 8, 0, 0, 1);
        add(0, 0, 0, 8, 0, 0, 1);
        add(0, 0, 1, 7, 0, 0, 1);
        add(0, 0, 0, 7, 0, 0, 1);
        add(1, 2, 1, 2, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 1);
        if (AUTO) begin
            add(0, 0, 1, 2, 0, 1, 1);
            add(0, 0, 1, 1, 0, 0, 1);
        end else begin
            add(0, 0, 1, 0, 1, 1, 0);
            add(0, 0, 1, 0, 1, 0, 0);
        end
        add(1, 0, 1, 0, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);
        add(1, 15, 0, 15, 0, 0, 1);
        add(0, 0, 1, 14, 0, 0, 1);
        foreach (tbl[i]) begin
            step(tbl[i].l, tbl[i].lv, tbl[i].e);
            check($sformatf("vec%0d", i), tbl[i].o, tbl[i].z, tbl[i].t, tbl[i].b);
        end
        // load 5 then count out, then stay enabled for 10 more cycles
        step_chk("load5", 1'b1, 4'd5, 1'b0);
        for (int i = 0; i < 15; i++) step_chk("run5", 1'b0, 4'd0, 1'b1);
        // load wins over a coincident terminal step
        step_chk("load3", 1'b1, 4'd3, 1'b1);
        step_chk("dec3", 1'b0, 4'd0, 1'b1);
        step_chk("dec3", 1'b0, 4'd0, 1'b1);
        step(1'b1, 4'd6, 1'b1);
        check("load_over_tc", 4'd6, 1'b0, 1'b0, 1'b1);
        // asynchronous reset between edges mid-count
        step_chk("load4", 1'b1, 4'd4, 1'b0);
        step_chk("dec4", 1'b0, 4'd0, 1'b1);
        step_chk("dec4", 1'b0, 4'd0, 1'b1);
        #3 rst = 1'b0;
        #1;
        model_reset();
        check("async_rst", 4'd0, 1'b1, 1'b0, 1'b0);
        step_chk("rst_held", 1'b0, 4'd0, 1'b1);
        #3 rst = 1'b1;
        step_chk("after_rst", 1'b0, 4'd0, 1'b1);
        // periodic vs one-shot terminal count
        step_chk("load3b", 1'b1, 4'd3, 1'b0);
        tcs = 0;
        for (int i = 0; i < 9; i++) begin
            step_chk("run3", 1'b0, 4'd0, 1'b1);
            tcs += int'(bus.tc);
        end
        n_cmp++;
        if (tcs != (AUTO ? 3 : 1)) begin
            n_bad++;
            $display("FAIL tc_count: got %0d, want %0d", tcs, AUTO ? 3 : 1);
        end
        for (int i = 0; i < 400; i++)
            step_chk("rand", ($urandom_range(7) == 0), W'($urandom_range(15)), ($urandom_range(3) != 0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
